hp_alarm_logger: RTL

//  Downstream consumer of the wb_hp alarm output. Edge-detects hp_alarm, stamps each event with a

---
 rtl/hp_alarm_logger_if.sv | 16 +
 rtl/hp_alarm_logger.sv | 95 +++++++++
 2 files changed

// File: rtl/hp_alarm_logger_if.sv
// hp_alarm_logger_if: Wishbone slave bus bundle for hp_alarm_logger
//   master drives cyc/stb/we/adr/dat_i; slave returns ack/stl/dat_o
interface hp_alarm_logger_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic        wbs_stl_o;
  logic [31:0] wbs_dat_o;
  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_stl_o, wbs_dat_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_stl_o, wbs_dat_o);
endinterface

// File: rtl/hp_alarm_logger.sv
// hp_alarm_logger: timestamps hp_alarm rising edges into a FIFO drained over Wishbone
//   wb_clk_i  clock; reset sync active-high
//   bus       Wishbone slave (hp_alarm_logger_if.slave): STATUS/DATA/CTRL/TS at adr[3:2]
//   hp_alarm  asynchronous alarm input
//   irq_o     present only when HP_LOG_IRQ_EN is defined
module hp_alarm_logger #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          TS_W       = 24
) (
  input logic              wb_clk_i,
  input logic              reset,
  hp_alarm_logger_if.slave bus,
  input logic              hp_alarm
`ifdef HP_LOG_IRQ_EN
  ,
  output logic             irq_o
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW = 32 - TS_W;
  logic [2:0] sync;
  logic [TS_W-1:0] ts;
  logic [SW-1:0] seq;
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, count;
  logic [31:0] mem [DEPTH];
  logic en, ovf, ie;
  logic [7:0] drop_ctr;
  logic [1:0] sel;
  logic evt, req, rd, ctrl_wr, empty, full, pop, flush, clr, zero, push, drop;
  logic [31:0] status, ctrl_rd, rd_data;
  logic unused_bits;
  assign unused_bits = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i};
  assign bus.wbs_stl_o = 1'b0;
  assign evt = sync[1] & ~sync[2];
  assign sel = bus.wbs_adr_i[3:2];
  assign req = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign rd = req & ~bus.wbs_we_i;
  assign ctrl_wr = req & bus.wbs_we_i & (sel == 2'd2);
  assign flush = ctrl_wr & bus.wbs_dat_i[1];
  assign clr = ctrl_wr & bus.wbs_dat_i[2];
  assign zero = ctrl_wr & bus.wbs_dat_i[3];
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  assign pop = rd & (sel == 2'd1) & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the event
  assign push = evt & en & ~flush & (~full | pop);
  assign drop = evt & en & ~flush & full & ~pop;
  assign status = {drop_ctr, 5'd0, ovf, full, empty, (15-DEPTH_LOG2)'(0), count};
  assign ctrl_rd = {27'd0, ie, 3'd0, en};
  assign rd_data = sel == 2'd0 ? status :
                   sel == 2'd1 ? (pop ? mem[rd_ptr[DEPTH_LOG2-1:0]] : 32'd0) :
                   sel == 2'd2 ? ctrl_rd : 32'(ts);
  always_ff @(posedge wb_clk_i)
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {seq, ts};
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      sync <= '0;
      ts <= '0;
      seq <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      en <= 1'b0;
      ovf <= 1'b0;
      drop_ctr <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
    end else begin
      sync <= {sync[1:0], hp_alarm};
      ts <= zero ? '0 : ts + TS_W'(1);
      seq <= zero ? '0 : seq + SW'(push);
      wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(push);
      rd_ptr <= flush ? wr_ptr : rd_ptr + (DEPTH_LOG2+1)'(pop);
      en <= ctrl_wr ? bus.wbs_dat_i[0] : en;
      ovf <= clr ? 1'b0 : ovf | drop;
      drop_ctr <= clr ? '0 : drop_ctr + 8'(drop && drop_ctr != 8'hff);
      bus.wbs_ack_o <= req;
      bus.wbs_dat_o <= rd ? rd_data : '0;
    end
  end
`ifdef HP_LOG_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      ie <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      ie <= ctrl_wr ? bus.wbs_dat_i[4] : ie;
      irq_o <= (~empty & ie) | ovf;
    end
  end
`else
  assign ie = 1'b0;
`endif
endmodule
